// File: rtl/imem_dmem_port_arbiter.sv
// imem_dmem_port_arbiter
// Shares one single-ported, fixed-latency unified memory between instruction
// fetch (IF) and data access (D). Only one transaction is outstanding at a time,
// and its response is routed back to the requester that owns it.
// Data requests win ties. A streak counter forces a fetch grant after
// MAX_D_STREAK consecutive data grants that were made while a fetch was waiting.
// Optional build macro ARB_PERF_CNT_EN adds saturating grant and stall counters.
// When the macro is undefined, the perf_* ports are tied to zero.

module imem_dmem_port_arbiter #(
   parameter int MEM_LAT      = 2,
   parameter int MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] perf_if_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_if_stall
);

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;

   localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   state_t     state;
   owner_t     owner;
   logic       owner_we;
   logic [3:0] lat_cnt;
   logic [3:0] streak;

   logic resp;
   logic accept;
   logic grant_d;
   logic grant_if;

   // The response cycle is also an accept cycle, so a new transaction can
   // overlap the return of the previous one and throughput stays at one
   // transaction per MEM_LAT cycles. Reset suppresses both the grant and the
   // response, so an in-flight transaction is simply dropped.
   assign resp     = !rst && (state == BUSY) && (lat_cnt == 4'd1);
   assign accept   = !rst && ((state == IDLE) || (lat_cnt == 4'd1));
   assign grant_d  = accept && d_req && (!if_req || (streak != STREAK_MAX));
   assign grant_if = accept && if_req && !grant_d;

   assign if_gnt    = grant_if;
   assign d_gnt     = grant_d;
   assign mem_req   = grant_d || grant_if;
   assign mem_we    = grant_d && d_we;
   assign mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : 32'd0);
   assign mem_wdata = grant_d ? d_wdata : 32'd0;

   assign if_rvalid = resp && (owner == OWN_IF);
   assign if_rdata  = (resp && (owner == OWN_IF)) ? mem_rdata : 32'd0;
   assign d_rvalid  = resp && (owner == OWN_D);
   assign d_rdata   = (resp && (owner == OWN_D) && !owner_we) ? mem_rdata : 32'd0;

   // Sequencer: latch the winner on a grant, count the latency down while BUSY,
   // and track how many data grants in a row have made a fetch wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= OWN_IF;
         owner_we <= 1'b0;
         lat_cnt  <= 4'd0;
         streak   <= 4'd0;
      end else if (grant_d || grant_if) begin
         state    <= BUSY;
         owner    <= grant_d ? OWN_D : OWN_IF;
         owner_we <= grant_d && d_we;
         lat_cnt  <= LAT_LOAD;
         if (grant_d && if_req) begin
            if (streak != STREAK_MAX) begin
               streak <= streak + 4'd1;
            end
         end else begin
            streak <= 4'd0;
         end
      end else if (state == BUSY) begin
         if (lat_cnt == 4'd1) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
         end else begin
            lat_cnt <= lat_cnt - 4'd1;
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Saturating counters for grants per requester and for fetch-stall cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_if_grants <= 32'd0;
         perf_d_grants  <= 32'd0;
         perf_if_stall  <= 32'd0;
      end else begin
         if (grant_if) begin
            perf_if_grants <= sat_inc(perf_if_grants);
         end
         if (grant_d) begin
            perf_d_grants <= sat_inc(perf_d_grants);
         end
         if (if_req && !grant_if) begin
            perf_if_stall <= sat_inc(perf_if_stall);
         end
      end
   end
`else
   assign perf_if_grants = 32'd0;
   assign perf_d_grants  = 32'd0;
   assign perf_if_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// tb_imem_dmem_port_arbiter
// Directed scenarios followed by randomized traffic. Every cycle is compared
// against a transaction-level reference model. A small memory model drives
// mem_rdata: read data appears MEM_LAT cycles after a read is issued, and random
// garbage is driven in every other cycle.

module tb_imem_dmem_port_arbiter;

   localparam int MEM_LAT      = 2;
   localparam int MAX_D_STREAK = 4;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] perf_if_grants;
   logic [31:0] perf_d_grants;
   logic [31:0] perf_if_stall;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: the single outstanding transaction and the arbitration history.
   int          out_cyc = -1;
   bit          out_is_d;
   bit          out_we;
   logic [31:0] out_addr;
   int          streak_m = 0;
   logic [31:0] m_if_grants = 0;
   logic [31:0] m_d_grants  = 0;
   logic [31:0] m_if_stall  = 0;
   bit          exp_gi;
   bit          exp_gd;

   logic [31:0] ret_data [int];

   imem_dmem_port_arbiter #(.MEM_LAT(MEM_LAT), .MAX_D_STREAK(MAX_D_STREAK)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
      .perf_if_stall(perf_if_stall)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit ir, input logic [31:0] ia,
                                input bit dr, input bit dw, input logic [31:0] da,
                                input logic [31:0] dwd);
      @(posedge clk);
      #1;
      cyc++;
      rst     = r;
      if_req  = ir;
      if_addr = ia;
      d_req   = dr;
      d_we    = dw;
      d_addr  = da;
      d_wdata = dwd;
      if (ret_data.exists(cyc)) begin
         mem_rdata = ret_data[cyc];
         ret_data.delete(cyc);
      end else begin
         mem_rdata = $urandom;
      end
   endtask

   task automatic checkOutput();
      bit          accept;
      bit          resp;
      logic [31:0] e_addr;
      logic [31:0] e_pif;
      logic [31:0] e_pd;
      logic [31:0] e_pst;
      #3;
      resp   = !rst && (out_cyc == cyc);
      accept = !rst && ((out_cyc < 0) || (out_cyc == cyc));
      exp_gd = accept && d_req && (!if_req || (streak_m < MAX_D_STREAK));
      exp_gi = accept && if_req && !exp_gd;
      e_addr = exp_gd ? d_addr : (exp_gi ? if_addr : 32'd0);
`ifdef ARB_PERF_CNT_EN
      e_pif = m_if_grants;
      e_pd  = m_d_grants;
      e_pst = m_if_stall;
`else
      e_pif = 32'd0;
      e_pd  = 32'd0;
      e_pst = 32'd0;
`endif
      chk("if_gnt", 32'(if_gnt), 32'(exp_gi));
      chk("d_gnt", 32'(d_gnt), 32'(exp_gd));
      chk("mem_req", 32'(mem_req), 32'(exp_gd || exp_gi));
      chk("mem_we", 32'(mem_we), 32'(exp_gd && d_we));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, exp_gd ? d_wdata : 32'd0);
      chk("if_rvalid", 32'(if_rvalid), 32'(resp && !out_is_d));
      chk("if_rdata", if_rdata, (resp && !out_is_d) ? mem_word(out_addr) : 32'd0);
      chk("d_rvalid", 32'(d_rvalid), 32'(resp && out_is_d));
      chk("d_rdata", d_rdata, (resp && out_is_d && !out_we) ? mem_word(out_addr) : 32'd0);
      chk("perf_if_grants", perf_if_grants, e_pif);
      chk("perf_d_grants", perf_d_grants, e_pd);
      chk("perf_if_stall", perf_if_stall, e_pst);

      if (mem_req === 1'b1 && mem_we === 1'b0) begin
         ret_data[cyc + MEM_LAT] = mem_word(mem_addr);
      end

      if (rst) begin
         out_cyc     = -1;
         streak_m    = 0;
         m_if_grants = 0;
         m_d_grants  = 0;
         m_if_stall  = 0;
      end else begin
         if (if_req && !exp_gi) m_if_stall++;
         if (exp_gd || exp_gi) begin
            out_cyc  = cyc + MEM_LAT;
            out_is_d = exp_gd;
            out_we   = exp_gd && d_we;
            out_addr = e_addr;
            if (exp_gi) begin
               m_if_grants++;
               streak_m = 0;
            end else begin
               m_d_grants++;
               streak_m = if_req ? streak_m + 1 : 0;
            end
         end else if (out_cyc == cyc) begin
            out_cyc = -1;
         end
      end
   endtask

   // Directed scenarios first, then randomized traffic with held requests.
   initial begin
      int          start;
      int          first_if;
      bit          ir;
      bit          dr;
      bit          dw;
      bit          r;
      logic [31:0] ia;
      logic [31:0] da;
      logic [31:0] dwd;

      rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0;

      $display("[TB] reset");
      repeat (2) begin applyStimulus(1, 1, 32'h40, 1, 0, 32'h80, 32'h0); checkOutput(); end

      $display("[TB] single fetch");
      applyStimulus(0, 1, 32'h10, 0, 0, 32'h0, 32'h0); checkOutput();
      repeat (3) begin applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0); checkOutput(); end

      $display("[TB] simultaneous requests and starvation guard");
      start    = cyc + 1;
      first_if = -1;
      repeat (12) begin
         applyStimulus(0, 1, 32'h20, 1, 0, 32'h100, 32'h0); checkOutput();
         if (if_gnt === 1'b1 && first_if < 0) first_if = cyc - start;
      end
      chk("starve_if_grant_cycle", 32'(first_if), 32'd8);
      repeat (3) begin applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0); checkOutput(); end

      $display("[TB] store");
      applyStimulus(0, 0, 32'h0, 1, 1, 32'h200, 32'hDEAD_BEEF); checkOutput();
      repeat (3) begin applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0); checkOutput(); end

      $display("[TB] reset mid-transaction");
      applyStimulus(0, 1, 32'h30, 0, 0, 32'h0, 32'h0); checkOutput();
      applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0); checkOutput();
      applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0); checkOutput();
      applyStimulus(0, 1, 32'h34, 0, 0, 32'h0, 32'h0); checkOutput();
      repeat (3) begin applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0); checkOutput(); end

      $display("[TB] randomized traffic");
      ir = 0; dr = 0; dw = 0; ia = '0; da = '0; dwd = '0;
      exp_gi = 0; exp_gd = 0; r = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!ir || exp_gi || r) begin
            ir = ($urandom_range(0, 99) < 60);
            ia = $urandom & 32'hFFFF_FFFC;
         end else if ($urandom_range(0, 99) < 5) begin
            ir = 0;
         end
         if (!dr || exp_gd || r) begin
            dr  = ($urandom_range(0, 99) < 55);
            dw  = $urandom_range(0, 1);
            da  = $urandom & 32'hFFFF_FFFC;
            dwd = $urandom;
         end else if ($urandom_range(0, 99) < 5) begin
            dr = 0;
         end
         r = ($urandom_range(0, 99) < 2);
         applyStimulus(r, ir, ia, dr, dw, da, dwd);
         checkOutput();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
